// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I load/store width codes and the timeout counter sizing helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int timeout_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication,
// alignment/legality checks and load-data extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o         = 4'b0000;
        wdata_rep_o  = 32'h0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        load_data_o  = 32'h0;
        byte_sel     = rdata_i[8*addr_lo_i +: 8];
        half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // funct3[1:0] encodes the access width identically for loads and stores.
        case (funct3_i[1:0])
            2'b00: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o  = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            2'b10: begin
                be_o         = 4'b1111;
                wdata_rep_o  = wdata_i;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase

        if (mem_read_i && mem_write_i)
            illegal_o = 1'b1;
        else if (mem_read_i)
            illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
        else if (mem_write_i)
            illegal_o = funct3_i[2] || (funct3_i[1:0] == 2'b11);

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data_o = rdata_i;
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one load/store at a time over a valid/ack
// bus, stalling the core until the registered response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       alo_q, alo_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mis_q, mis_d;
    logic             err_q, err_d;

    logic        accept;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_mis;
    logic        al_ill;
    logic [31:0] al_load;

    assign accept = (state_q == S_IDLE) && req_valid && (mem_read || mem_write);

    // While waiting on the bus the aligner must see the latched request, not the live inputs.
    assign al_f3 = (state_q == S_ACCESS) ? f3_q  : funct3;
    assign al_lo = (state_q == S_ACCESS) ? alo_q : addr[1:0];

    lsu_align u_align (
        .funct3_i     (al_f3),
        .addr_lo_i    (al_lo),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .wdata_i      (wdata),
        .rdata_i      (bus_rdata),
        .be_o         (al_be),
        .wdata_rep_o  (al_wdata),
        .misaligned_o (al_mis),
        .illegal_o    (al_ill),
        .load_data_o  (al_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= 3'b000;
            alo_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            alo_q       <= alo_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            mis_q       <= mis_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = 1'b0;
        rdata_d     = 32'h0;
        mis_d       = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (al_ill) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else if (al_mis) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        mis_d       = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        f3_d        = funct3;
                        alo_d       = addr[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = al_be;
                        bus_wdata_d = al_wdata;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_err || bus_ack || (cnt_q == CNT_LAST)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    bus_req_d   = 1'b0;
                    // A bus error outranks an ack seen in the same cycle.
                    if (bus_err || !bus_ack)
                        err_d = 1'b1;
                    else if (!bus_we_q)
                        rdata_d = al_load;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign stall     = accept || (state_q == S_ACCESS);
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign misaligned = mis_q;
    assign err       = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short bus timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_ready, stall, rsp_valid, misaligned, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid),
        .rdata(rdata), .misaligned(misaligned), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; wdata = wd;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end n_checks++;
        if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end n_checks++;
        if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL rst_bus_addr got=%h exp=0", bus_addr); end n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rdata); end n_checks++;
        if ({misaligned, err} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got=%b exp=00", {misaligned, err}); end n_checks++;
        if ({req_ready, stall} !== 2'b10) begin n_fail++; $display("FAIL rst_ready_stall got=%b exp=10", {req_ready, stall}); end n_checks++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_store_word();
        drive(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF);
        #1;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL sw_stall_idle got=%b exp=1", stall); end n_checks++;
        tick();
        if (bus_req !== 1'b1) begin n_fail++; $display("FAIL sw_bus_req got=%b exp=1", bus_req); end n_checks++;
        if (bus_we !== 1'b1) begin n_fail++; $display("FAIL sw_bus_we got=%b exp=1", bus_we); end n_checks++;
        if (bus_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL sw_bus_addr got=%h exp=00001004", bus_addr); end n_checks++;
        if (bus_be !== 4'b1111) begin n_fail++; $display("FAIL sw_bus_be got=%b exp=1111", bus_be); end n_checks++;
        if (bus_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_bus_wdata got=%h exp=deadbeef", bus_wdata); end n_checks++;
        if ({rsp_valid, req_ready} !== 2'b00) begin n_fail++; $display("FAIL sw_early_rsp got=%b exp=00", {rsp_valid, req_ready}); end n_checks++;
        bus_ack = 1'b1;
        tick();
        if ({rsp_valid, err, misaligned} !== 3'b100) begin n_fail++; $display("FAIL sw_rsp got=%b exp=100", {rsp_valid, err, misaligned}); end n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got=%h exp=0", rdata); end n_checks++;
        if ({bus_req, stall} !== 2'b00) begin n_fail++; $display("FAIL sw_resp_req_stall got=%b exp=00", {bus_req, stall}); end n_checks++;
        idle_inputs();
        tick();
        if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL sw_back_idle got=%b exp=01", {rsp_valid, req_ready}); end n_checks++;
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, 32'h0000_2003, 32'h0);
        tick();
        if (bus_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be f3=%0d got=%b exp=1000", f3, bus_be); end n_checks++;
        if ({bus_req, bus_we} !== 2'b10) begin n_fail++; $display("FAIL lb_req_we f3=%0d got=%b exp=10", f3, {bus_req, bus_we}); end n_checks++;
        for (int i = 0; i < 2; i++) begin
            tick();
            if ({stall, rsp_valid, bus_req} !== 3'b101) begin n_fail++; $display("FAIL lb_wait%0d f3=%0d got=%b exp=101", i, f3, {stall, rsp_valid, bus_req}); end n_checks++;
        end
        bus_ack = 1'b1; bus_rdata = 32'h8012_3456;
        tick();
        if ({rsp_valid, err, stall} !== 3'b100) begin n_fail++; $display("FAIL lb_rsp f3=%0d got=%b exp=100", f3, {rsp_valid, err, stall}); end n_checks++;
        if (rdata !== exp) begin n_fail++; $display("FAIL lb_rdata f3=%0d got=%h exp=%h", f3, rdata, exp); end n_checks++;
        idle_inputs();
        tick();
    endtask

    task automatic test_load_half(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h8001_7FFF;
        tick();
        if (rdata !== exp) begin n_fail++; $display("FAIL lh_rdata f3=%0d got=%h exp=%h", f3, rdata, exp); end n_checks++;
        idle_inputs();
        tick();
    endtask

    task automatic test_store_lanes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] exp_be, input logic [31:0] exp_wd);
        drive(1'b0, 1'b1, f3, a, wd);
        tick();
        if (bus_be !== exp_be) begin n_fail++; $display("FAIL st_be f3=%0d got=%b exp=%b", f3, bus_be, exp_be); end n_checks++;
        if (bus_wdata !== exp_wd) begin n_fail++; $display("FAIL st_wdata f3=%0d got=%h exp=%h", f3, bus_wdata, exp_wd); end n_checks++;
        if (bus_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL st_addr f3=%0d got=%h exp=00000010", f3, bus_addr); end n_checks++;
        bus_ack = 1'b1;
        tick();
        if ({rsp_valid, err} !== 2'b10) begin n_fail++; $display("FAIL st_rsp f3=%0d got=%b exp=10", f3, {rsp_valid, err}); end n_checks++;
        idle_inputs();
        tick();
    endtask

    task automatic test_no_bus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic exp_mis, input logic exp_err);
        drive(rd, wr, f3, a, 32'h1111_1111);
        tick();
        if ({rsp_valid, misaligned, err} !== {1'b1, exp_mis, exp_err}) begin n_fail++; $display("FAIL nobus_flags f3=%0d got=%b exp=%b", f3, {rsp_valid, misaligned, err}, {1'b1, exp_mis, exp_err}); end n_checks++;
        if ({bus_req, rdata} !== 33'h0) begin n_fail++; $display("FAIL nobus_req_rdata f3=%0d got=%b/%h exp=0/0", f3, bus_req, rdata); end n_checks++;
        idle_inputs();
        tick();
        if ({bus_req, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL nobus_after f3=%0d got=%b exp=00", f3, {bus_req, rsp_valid}); end n_checks++;
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        bus_rdata = 32'hFFFF_FFFF;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if ({bus_req, rsp_valid, stall} !== 3'b101) begin n_fail++; $display("FAIL to_wait%0d got=%b exp=101", i, {bus_req, rsp_valid, stall}); end n_checks++;
        end
        tick();
        if ({bus_req, rsp_valid, err} !== 3'b011) begin n_fail++; $display("FAIL to_rsp got=%b exp=011", {bus_req, rsp_valid, err}); end n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got=%h exp=0", rdata); end n_checks++;
        idle_inputs();
        tick();
    endtask

    task automatic test_bus_err();
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tick();
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        if ({rsp_valid, err, misaligned} !== 3'b110) begin n_fail++; $display("FAIL be_rsp got=%b exp=110", {rsp_valid, err, misaligned}); end n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL be_rdata got=%h exp=0", rdata); end n_checks++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D);
        tick();
        tick();
        if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rm_pre_req got=%b exp=1", bus_req); end n_checks++;
        reset = 1'b1;
        idle_inputs();
        tick();
        if ({bus_req, bus_we, bus_be} !== 6'h0) begin n_fail++; $display("FAIL rm_ctrl got=%b exp=000000", {bus_req, bus_we, bus_be}); end n_checks++;
        if ({bus_addr, bus_wdata} !== 64'h0) begin n_fail++; $display("FAIL rm_bus got=%h/%h exp=0/0", bus_addr, bus_wdata); end n_checks++;
        if ({rsp_valid, misaligned, err, req_ready} !== 4'b0001) begin n_fail++; $display("FAIL rm_flags got=%b exp=0001", {rsp_valid, misaligned, err, req_ready}); end n_checks++;
        reset = 1'b0;
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({rsp_valid, bus_req, req_ready} !== 3'b001) begin n_fail++; $display("FAIL rm_stray_ack%0d got=%b exp=001", i, {rsp_valid, bus_req, req_ready}); end n_checks++;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte(3'b000, 32'hFFFF_FF80);
        test_load_byte(3'b100, 32'h0000_0080);
        test_load_half(3'b001, 32'h0000_0002, 32'hFFFF_8001);
        test_load_half(3'b101, 32'h0000_0000, 32'h0000_7FFF);
        test_store_lanes(3'b001, 32'h0000_0010, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD);
        test_store_lanes(3'b000, 32'h0000_0011, 32'h0000_0055, 4'b0010, 32'h5555_5555);
        test_no_bus(1'b1, 1'b0, 3'b010, 32'h0000_2002, 1'b1, 1'b0);
        test_no_bus(1'b1, 1'b1, 3'b010, 32'h0000_0100, 1'b0, 1'b1);
        test_no_bus(1'b1, 1'b0, 3'b011, 32'h0000_0100, 1'b0, 1'b1);
        test_no_bus(1'b0, 1'b1, 3'b100, 32'h0000_0100, 1'b0, 1'b1);
        test_timeout();
        test_bus_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
